alu_ctrl_sequencer: RTL

//  Registered, handshaked ALU control stage between decode and execute. Decodes {alu_op, funct7, funct3} for
//  RV32I (optionally RV32M) into a CTRL_W-bit ALU control word plus an illegal flag. Multi-cycle ops (MUL*/DIV*/REM*)
//  are held behind a down-counter so execute sees the result slot only when the unit is done.

---
 rtl/alu_ctrl_sequencer.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/alu_ctrl_sequencer.sv
// -----------------------------------------------------------------------------
// alu_ctrl_sequencer
//   Registered, handshaked ALU control stage sitting between decode and
//   execute. Decodes {alu_op, funct7, funct3} for RV32I (optionally RV32M)
//   into an ALU control word plus an illegal flag. Multiply/divide ops are
//   held behind a down-counter so execute only sees them once the unit is done.
//
// Configuration macro:
//   RV32M_EN  - when defined, alu_op=10 with funct7=0000001 decodes the M ops.
//               When undefined those encodings are illegal and the WAIT state
//               is never entered (busy stays 0).
//
// Ports:
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   flush             synchronous flush; drops in-flight op and coincident input
//   in_valid/in_ready decode-side handshake
//   alu_op/funct7/funct3  instruction fields to decode
//   out_valid/out_ready   execute-side handshake
//   alu_control       ADD0 SUB1 AND2 OR3 XOR4 SLL5 SRL6 SRA7 SLT8 SLTU9
//                     MUL10 MULH11 MULHSU12 MULHU13 DIV14 DIVU15 REM16 REMU17
//   illegal           unsupported encoding (alu_control = ADD)
//   busy              multi-cycle op in progress
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module alu_ctrl_sequencer #(
  parameter int CTRL_W  = 5,
  parameter int MUL_LAT = 3,
  parameter int DIV_LAT = 32,
  parameter int CNT_W   = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        alu_op,
  input  logic [6:0]        funct7,
  input  logic [2:0]        funct3,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] alu_control,
  output logic              illegal,
  output logic              busy
);

  typedef enum logic [4:0] {
    OP_ADD = 5'd0,  OP_SUB  = 5'd1,  OP_AND  = 5'd2,  OP_OR   = 5'd3,
    OP_XOR = 5'd4,  OP_SLL  = 5'd5,  OP_SRL  = 5'd6,  OP_SRA  = 5'd7,
    OP_SLT = 5'd8,  OP_SLTU = 5'd9,  OP_MUL  = 5'd10
  } ctrl_e;

  typedef enum logic [1:0] {IDLE, WAIT, HOLD} state_e;

  state_e             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [CTRL_W-1:0]  alu_control_q;
  logic               illegal_q, out_valid_q, busy_q;

  ctrl_e              ctrl_d;
  logic               illegal_d, is_mul_d, is_div_d;
  logic               accept, need_wait;
  logic [CNT_W-1:0]   load_cnt;

  // Decode of the instruction fields.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    ctrl_d    = OP_ADD;
    illegal_d = 1'b0;
    is_mul_d  = 1'b0;
    is_div_d  = 1'b0;
    unique case (alu_op)
      2'b00: ctrl_d = OP_ADD;
      2'b01: begin
        unique case (funct3[2:1])
          2'b00:   ctrl_d = OP_SUB;
          2'b10:   ctrl_d = OP_SLT;
          2'b11:   ctrl_d = OP_SLTU;
          default: illegal_d = 1'b1;
        endcase
      end
      2'b10: begin
        if (funct7 == 7'b0000000) begin
          unique case (funct3)
            3'b000: ctrl_d = OP_ADD;
            3'b001: ctrl_d = OP_SLL;
            3'b010: ctrl_d = OP_SLT;
            3'b011: ctrl_d = OP_SLTU;
            3'b100: ctrl_d = OP_XOR;
            3'b101: ctrl_d = OP_SRL;
            3'b110: ctrl_d = OP_OR;
            3'b111: ctrl_d = OP_AND;
          endcase
        end else if (funct7 == 7'b0100000) begin
          if (funct3 == 3'b000)      ctrl_d = OP_SUB;
          else if (funct3 == 3'b101) ctrl_d = OP_SRA;
          else                       illegal_d = 1'b1;
        end else if (funct7 == 7'b0000001) begin
`ifdef RV32M_EN
          // M ops are numbered consecutively from MUL in funct3 order.
          ctrl_d   = ctrl_e'(5'd10 + {2'b00, funct3});
          is_mul_d = ~funct3[2];
          is_div_d = funct3[2];
`else
          illegal_d = 1'b1;
`endif
        end else begin
          illegal_d = 1'b1;
        end
      end
      2'b11: begin
        unique case (funct3)
          3'b000: ctrl_d = OP_ADD;
          3'b001: if (funct7 == 7'b0000000) ctrl_d = OP_SLL; else illegal_d = 1'b1;
          3'b010: ctrl_d = OP_SLT;
          3'b011: ctrl_d = OP_SLTU;
          3'b100: ctrl_d = OP_XOR;
          3'b101: begin
            if (funct7 == 7'b0000000)      ctrl_d = OP_SRL;
            else if (funct7 == 7'b0100000) ctrl_d = OP_SRA;
            else                           illegal_d = 1'b1;
          end
          3'b110: ctrl_d = OP_OR;
          3'b111: ctrl_d = OP_AND;
        endcase
      end
    endcase
    if (illegal_d) ctrl_d = OP_ADD;
  end

  // Handshake and multi-cycle load values.
  always_comb begin
    in_ready  = ~flush & ((state_q == IDLE) | ((state_q == HOLD) & out_ready));
    accept    = in_valid & in_ready;
    need_wait = (is_mul_d && (MUL_LAT > 1)) || (is_div_d && (DIV_LAT > 1));
    // Counter starts at LAT-2: one cycle is spent entering WAIT, one leaving it.
    load_cnt  = is_div_d ? CNT_W'(DIV_LAT - 2) : CNT_W'(MUL_LAT - 2);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    if (!rst_n) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      alu_control_q <= '0;
      illegal_q     <= 1'b0;
      out_valid_q   <= 1'b0;
      busy_q        <= 1'b0;
    end else if (flush) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE, HOLD: begin
          if (accept) begin
            alu_control_q <= CTRL_W'(ctrl_d);
            illegal_q     <= illegal_d;
            if (need_wait) begin
              state_q     <= WAIT;
              cnt_q       <= load_cnt;
              busy_q      <= 1'b1;
              out_valid_q <= 1'b0;
            end else begin
              state_q     <= HOLD;
              out_valid_q <= 1'b1;
            end
          end else if ((state_q == HOLD) && out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
          end
        end
        WAIT: begin
          if (cnt_q == '0) begin
            state_q     <= HOLD;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign alu_control = alu_control_q;
  assign illegal     = illegal_q;
  assign out_valid   = out_valid_q;
  assign busy        = busy_q;

endmodule
